// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave: oversampled SPI mode-0 slave that deserialises command/parameter bytes and shifts out a response byte
module mcu_spi_slave #(
  parameter int SYNC_STAGES = 3,
  parameter int BYTE_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCK,
  input  logic                  MOSI,
  input  logic                  SSEL,
  output logic                  MISO,
  output logic                  miso_oe,
  output logic                  cmd_ready,
  output logic                  param_ready,
  output logic [7:0]            cmd_data,
  output logic [7:0]            param_data,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [2:0]            bit_cnt,
  output logic                  startmessage,
  output logic                  endmessage,
  input  logic [7:0]            input_data
);
  typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_ACTIVE} state_t;
  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_q, mosi_q, ssel_q, flush_q;
  logic [7:0]              rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d, param_q, param_d;
  logic [BYTE_CNT_W-1:0]   byte_q, byte_d;
  logic [2:0]              bit_q, bit_d;
  logic                    oe_q, oe_d, cmd_rdy_q, cmd_rdy_d, par_rdy_q, par_rdy_d;
  logic                    start_q, start_d, end_q, end_d;
  logic                    sck_rise, sck_fall, ssel_act, ssel_end;
  logic [7:0]              rx_byte;
  // flush_q marks when the synchroniser holds only post-reset pin samples,
  // so a select still held low across reset cannot look like a fresh start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q   <= '0;
      mosi_q  <= '0;
      ssel_q  <= '1;
      flush_q <= '0;
    end else begin
      sck_q   <= {sck_q[SYNC_STAGES-2:0], SCK};
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      ssel_q  <= {ssel_q[SYNC_STAGES-2:0], SSEL};
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
    end
  end
  assign sck_rise = !sck_q[SYNC_STAGES-1] && sck_q[SYNC_STAGES-2];
  assign sck_fall = sck_q[SYNC_STAGES-1] && !sck_q[SYNC_STAGES-2];
  assign ssel_act = ssel_q[SYNC_STAGES-1] && !ssel_q[SYNC_STAGES-2];
  assign ssel_end = !ssel_q[SYNC_STAGES-1] && ssel_q[SYNC_STAGES-2];
  assign rx_byte  = {rx_q[6:0], mosi_q[SYNC_STAGES-2]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_IDLE;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      param_q   <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      oe_q      <= 1'b0;
      cmd_rdy_q <= 1'b0;
      par_rdy_q <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      param_q   <= param_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      oe_q      <= oe_d;
      cmd_rdy_q <= cmd_rdy_d;
      par_rdy_q <= par_rdy_d;
      start_q   <= start_d;
      end_q     <= end_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    param_d   = param_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    oe_d      = oe_q;
    cmd_rdy_d = 1'b0;
    par_rdy_d = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    case (state_q)
      S_WAIT_IDLE: state_d = (flush_q[SYNC_STAGES-1] && &ssel_q) ? S_IDLE : S_WAIT_IDLE;
      S_IDLE: if (ssel_act) begin
        state_d = S_ACTIVE;
        start_d = 1'b1;
        byte_d  = '0;
        bit_d   = '0;
        tx_d    = input_data;
        oe_d    = 1'b1;
      end
      S_ACTIVE: if (ssel_end) begin
        state_d = S_IDLE;
        end_d   = 1'b1;
        oe_d    = 1'b0;
        bit_d   = '0;
      end else if (sck_rise) begin
        rx_d  = rx_byte;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_d    = byte_q + BYTE_CNT_W'(1);
          cmd_rdy_d = byte_q == '0;
          par_rdy_d = byte_q != '0;
          cmd_d     = (byte_q == '0) ? rx_byte : cmd_q;
          param_d   = (byte_q != '0) ? rx_byte : param_q;
        end
      end else if (sck_fall) begin
        tx_d = (bit_q == 3'd0) ? input_data : {tx_q[6:0], 1'b0};
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end
  assign MISO         = oe_q && tx_q[7];
  assign miso_oe      = oe_q;
  assign cmd_ready    = cmd_rdy_q;
  assign param_ready  = par_rdy_q;
  assign cmd_data     = cmd_q;
  assign param_data   = param_q;
  assign byte_cnt     = byte_q;
  assign bit_cnt      = bit_q;
  assign startmessage = start_q;
  assign endmessage   = end_q;
endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- SPI slave front end between the MCU SPI pins and the command decoder.
- Oversamples SCK, MOSI and SSEL in the FPGA clock domain and deserialises bytes MSB-first (SPI mode 0).
- Presents command and parameter bytes with single-cycle ready strobes, byte/bit counters and message start/end strobes.
- Serialises the decoder's response byte onto MISO.

Parameters:
SYNC_STAGES, 3, synchroniser depth for SCK/MOSI/SSEL (min 2)
BYTE_CNT_W, 32, width of byte_cnt

Ports:
clk  in  1  system clock; must be at least 4x the SCK frequency
rst_n  in  1  synchronous active-low reset
SCK  in  1  SPI clock from MCU, asynchronous
MOSI  in  1  SPI data from MCU
SSEL  in  1  SPI select, active low
MISO  out  1  SPI data to MCU
miso_oe  out  1  MISO output enable (1 while message active)
cmd_ready  out  1  1-cycle strobe: byte 0 of a message received
param_ready  out  1  1-cycle strobe: byte n>=1 received
cmd_data  out  8  first byte of current message, held until next message's byte 0
param_data  out  8  most recent byte n>=1
byte_cnt  out  BYTE_CNT_W  completed bytes in current message
bit_cnt  out  3  bits received in current byte
startmessage  out  1  1-cycle strobe on SSEL assertion
endmessage  out  1  1-cycle strobe on SSEL deassertion
input_data  in  8  response byte to shift out; sampled at byte boundary

Behaviour:
- Reset (rst_n=0 at posedge clk): MISO=0, miso_oe=0, cmd_ready=0, param_ready=0, cmd_data=0, param_data=0, byte_cnt=0, bit_cnt=0, startmessage=0, endmessage=0. Synchroniser history cleared to SCK=0, SSEL=1. FSM enters S_WAIT_IDLE.
- Synchronisation: SCK, MOSI and SSEL each pass through SYNC_STAGES flops. Edges are detected from the last two stages.
  - sck_rise = 01, sck_fall = 10, ssel_act = 10, ssel_end = 01.
  - MOSI is taken from the same stage as the sck_rise detector.
- FSM:
  - S_WAIT_IDLE: ignore everything until synchronised SSEL=1, then go to S_IDLE. A reset mid-message therefore discards the rest of that message.
  - S_IDLE: on ssel_act, go to S_ACTIVE and pulse startmessage. Same edge: byte_cnt<=0, bit_cnt<=0, tx_shift<=input_data, miso_oe<=1.
  - S_ACTIVE: on ssel_end, go to S_IDLE, pulse endmessage, miso_oe<=0, bit_cnt<=0. byte_cnt holds its value. A partial byte is discarded with no ready strobe.
  - ssel_end takes priority over an SCK edge in the same cycle.
- Receive (S_ACTIVE, on sck_rise):
  - rx_shift<={rx_shift[6:0],MOSI}; bit_cnt<=bit_cnt+1, wrapping 7->0.
  - When bit_cnt==7 (8th bit), register these together so they become visible in the same cycle:
    - byte_cnt<=byte_cnt+1.
    - If byte_cnt==0: cmd_data<={rx_shift[6:0],MOSI}, cmd_ready<=1.
    - Else: param_data<={rx_shift[6:0],MOSI}, param_ready<=1.
  - Resulting visible values: after the command byte, byte_cnt=1; during the first param_ready, byte_cnt=2.
  - Ready strobes and start/end strobes deassert on the following clk.
- byte_cnt wraps modulo 2^BYTE_CNT_W; no saturation.
- Transmit: MISO = tx_shift[7] while miso_oe=1, else 0.
  - On sck_fall in S_ACTIVE: if bit_cnt==0 (byte boundary), tx_shift<=input_data; else tx_shift<={tx_shift[6:0],1'b0}.
  - The falling edge after the 8th rising edge therefore loads the next response byte.
  - input_data must be stable from bit_cnt==7 onward. The decoder updates it at bit_cnt==7.
- SCK edges in S_IDLE or S_WAIT_IDLE have no effect.
- Latency: SYNC_STAGES+1 clk from the pin edge to the strobe or register update.

Test Plan:
- Single-byte message: SSEL low, send 0x3A, SSEL high -> startmessage 1 pulse; cmd_ready 1 pulse with cmd_data=0x3A, byte_cnt=1; endmessage 1 pulse; no param_ready; byte_cnt stays 1 until the next start.
- Command plus 3 params: send 0x10,0x12,0x34,0x56 -> one cmd_ready (cmd_data=0x10); three param_ready pulses with (param_data, byte_cnt) = (0x12,2), (0x34,3), (0x56,4); cmd_data held at 0x10 throughout.
- MISO response: input_data=0xA5 at start, set to 0x5C when bit_cnt==7 of byte 0 -> MCU samples 0xA5 during byte 0 and 0x5C during byte 1; miso_oe=0 and MISO=0 after SSEL high.
- Aborted byte: send 0x20 then 5 bits, then SSEL high -> only cmd_ready; no param_ready; endmessage pulses; the next message restarts at bit_cnt=0, byte_cnt=0.
- Reset mid-message: assert rst_n=0 for 2 clk after 12 bits with SSEL held low, continue clocking 8 bits -> all outputs at reset values, no strobes. After SSEL high then low again, 0x81 yields cmd_ready with cmd_data=0x81.
- Simultaneous edge plus speed limit: SSEL deassert in the same clk as the 8th SCK rise -> endmessage only, no ready. Run at SCK = clk/4 with 16-byte messages -> all bytes received correctly.
